cond_exec_stage: RTL and testbench

//   Execute-to-memory stage that consumes the 32-bit ALU result and its {N,Z,C,V} FLAGS.

---
 rtl/cond_exec_stage.sv | 122 ++++++++++++
 tb/tb_cond_exec_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_stage.sv
// ============================================================================
// Module   : cond_exec_stage
// Purpose  : Execute-to-memory stage. It holds the NZCV status register and
//            evaluates ARM condition codes to gate write enables. Results go
//            into a one-entry valid/ready output slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_exec_stage #(
    parameter int          WIDTH       = 32,
    parameter int          RA_W        = 4,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_w,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             pc_s,
    input  logic [RA_W-1:0]  wa3,
    input  logic [WIDTH-1:0] write_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_wd,
    output logic [RA_W-1:0]  out_wa3,
    output logic             out_reg_w,
    output logic             out_mem_w,
    output logic             out_pc_s,
    output logic [3:0]       flags_q,
    output logic             cond_ex
);

    localparam logic [3:0] C_EQ = 4'h0;
    localparam logic [3:0] C_NE = 4'h1;
    localparam logic [3:0] C_CS = 4'h2;
    localparam logic [3:0] C_CC = 4'h3;
    localparam logic [3:0] C_MI = 4'h4;
    localparam logic [3:0] C_PL = 4'h5;
    localparam logic [3:0] C_VS = 4'h6;
    localparam logic [3:0] C_VC = 4'h7;
    localparam logic [3:0] C_HI = 4'h8;
    localparam logic [3:0] C_LS = 4'h9;
    localparam logic [3:0] C_GE = 4'hA;
    localparam logic [3:0] C_LT = 4'hB;
    localparam logic [3:0] C_GT = 4'hC;
    localparam logic [3:0] C_LE = 4'hD;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_accept;

    assign w_n = flags_q[3];
    assign w_z = flags_q[2];
    assign w_c = flags_q[1];
    assign w_v = flags_q[0];

    // Condition reads only the committed flags, so a flag-setting instruction
    // in the slot is already visible to the instruction behind it.
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            C_EQ:    cond_ex = w_z;
            C_NE:    cond_ex = ~w_z;
            C_CS:    cond_ex = w_c;
            C_CC:    cond_ex = ~w_c;
            C_MI:    cond_ex = w_n;
            C_PL:    cond_ex = ~w_n;
            C_VS:    cond_ex = w_v;
            C_VC:    cond_ex = ~w_v;
            C_HI:    cond_ex = w_c & ~w_z;
            C_LS:    cond_ex = ~w_c | w_z;
            C_GE:    cond_ex = (w_n == w_v);
            C_LT:    cond_ex = (w_n != w_v);
            C_GT:    cond_ex = ~w_z & (w_n == w_v);
            C_LE:    cond_ex = w_z | (w_n != w_v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign in_ready = ~flush & (~out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_wd     <= '0;
            out_wa3    <= '0;
            out_reg_w  <= 1'b0;
            out_mem_w  <= 1'b0;
            out_pc_s   <= 1'b0;
            flags_q    <= FLAGS_RESET;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid  <= 1'b1;
            out_result <= alu_y;
            out_wd     <= write_data;
            out_wa3    <= wa3;
            out_reg_w  <= reg_w & cond_ex;
            out_mem_w  <= mem_w & cond_ex;
            out_pc_s   <= pc_s & cond_ex;
            if (cond_ex & flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
            if (cond_ex & flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cond_exec_stage.sv
// ============================================================================
// Module   : tb_cond_exec_stage
// Purpose  : Directed self-checking bench for cond_exec_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_y;
    logic [3:0]  alu_flags;
    logic [3:0]  cond;
    logic [1:0]  flag_w;
    logic        reg_w;
    logic        mem_w;
    logic        pc_s;
    logic [3:0]  wa3;
    logic [31:0] write_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_wd;
    logic [3:0]  out_wa3;
    logic        out_reg_w;
    logic        out_mem_w;
    logic        out_pc_s;
    logic [3:0]  flags_q;
    logic        cond_ex;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_exec_stage #(.WIDTH(32), .RA_W(4), .FLAGS_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_y(alu_y), .alu_flags(alu_flags), .cond(cond), .flag_w(flag_w),
        .reg_w(reg_w), .mem_w(mem_w), .pc_s(pc_s), .wa3(wa3),
        .write_data(write_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_wd(out_wd),
        .out_wa3(out_wa3), .out_reg_w(out_reg_w), .out_mem_w(out_mem_w),
        .out_pc_s(out_pc_s), .flags_q(flags_q), .cond_ex(cond_ex)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; alu_y = 0; alu_flags = 0; cond = 4'hE; flag_w = 0;
        reg_w = 0; mem_w = 0; pc_s = 0; wa3 = 0; write_data = 0; flush = 0;
        out_ready = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        step();
        step();
        reset = 0;
        step();
    endtask

    task automatic load_flags(input logic [3:0] f);
        in_valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = f;
        reg_w = 0; mem_w = 0; pc_s = 0;
        step();
        in_valid = 0; flag_w = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        step();
        step();
        checks++;
        if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags_q); end
        checks++;
        if ({out_result, out_wd, out_wa3, out_reg_w, out_mem_w, out_pc_s} !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%h/%h expected all zero", out_result, out_wd, out_wa3);
        end
        reset = 0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_al_flags();
        in_valid = 1; cond = 4'hE; flag_w = 2'b11; alu_y = 32'h0; alu_flags = 4'b0100;
        wa3 = 4'h7; write_data = 32'hCAFE_0001; reg_w = 1; mem_w = 1;
        step();
        in_valid = 0; flag_w = 0;
        checks++;
        if (flags_q !== 4'b0100) begin errors++; $display("FAIL al_flags: got %b expected 0100", flags_q); end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h0) begin
            errors++; $display("FAIL al_slot: got valid=%b result=%h expected valid=1 result=0", out_valid, out_result);
        end
        checks++;
        if (out_wa3 !== 4'h7 || out_wd !== 32'hCAFE_0001 || out_reg_w !== 1'b1 || out_mem_w !== 1'b1) begin
            errors++; $display("FAIL al_fields: got wa3=%h wd=%h rw=%b mw=%b expected 7 cafe0001 1 1",
                               out_wa3, out_wd, out_reg_w, out_mem_w);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL al_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_eq_ne();
        in_valid = 1; cond = 4'h0; reg_w = 1; mem_w = 0; flag_w = 0; alu_y = 32'h11;
        #1;
        checks++;
        if (cond_ex !== 1'b1) begin errors++; $display("FAIL eq_cond_ex: got %b expected 1", cond_ex); end
        step();
        checks++;
        if (out_reg_w !== 1'b1 || out_result !== 32'h11) begin
            errors++; $display("FAIL eq_slot: got rw=%b result=%h expected 1 11", out_reg_w, out_result);
        end
        cond = 4'h1; alu_y = 32'h22; mem_w = 1; flag_w = 2'b11; alu_flags = 4'b1011;
        step();
        in_valid = 0; flag_w = 0;
        checks++;
        if (out_reg_w !== 1'b0 || out_mem_w !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h22) begin
            errors++; $display("FAIL ne_bubble: got rw=%b mw=%b valid=%b result=%h expected 0 0 1 22",
                               out_reg_w, out_mem_w, out_valid, out_result);
        end
        checks++;
        if (flags_q !== 4'b0100) begin errors++; $display("FAIL ne_flags: got %b expected 0100", flags_q); end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        // CMP 5,5 : Z=1, C=1 (no borrow)
        in_valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b0110; alu_y = 0; pc_s = 0;
        step();
        cond = 4'h0; flag_w = 0; pc_s = 1; alu_y = 32'h100;
        step();
        in_valid = 0; pc_s = 0;
        checks++;
        if (out_pc_s !== 1'b1 || out_result !== 32'h100) begin
            errors++; $display("FAIL b2b_beq_taken: got pc_s=%b result=%h expected 1 100", out_pc_s, out_result);
        end
        do_reset();
        in_valid = 1; cond = 4'hE; flag_w = 2'b01; alu_flags = 4'b0110; pc_s = 0;
        step();
        cond = 4'h0; flag_w = 0; pc_s = 1;
        step();
        in_valid = 0; pc_s = 0;
        checks++;
        if (out_pc_s !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_beq_not_taken: got pc_s=%b valid=%b expected 0 1", out_pc_s, out_valid);
        end
        checks++;
        if (flags_q !== 4'b0010) begin errors++; $display("FAIL b2b_partial_flags: got %b expected 0010", flags_q); end
        step();
    endtask

    task automatic test_cond_table();
        logic [3:0]  fl  [3];
        logic [15:0] tbl [3];
        logic [15:0] e;
        fl[0] = 4'b1001; tbl[0] = 16'b1101_0110_0101_1010;
        fl[1] = 4'b1000; tbl[1] = 16'b1110_1010_1001_1010;
        fl[2] = 4'b0110; tbl[2] = 16'b1110_0110_1010_0101;
        for (int k = 0; k < 3; k++) begin
            load_flags(fl[k]);
            e = tbl[k];
            for (int c = 0; c < 16; c++) begin
                cond = c[3:0];
                #1;
                checks++;
                if (cond_ex !== e[c]) begin
                    errors++;
                    $display("FAIL cond_table flags=%b cond=%h: got %b expected %b", fl[k], c[3:0], cond_ex, e[c]);
                end
            end
        end
        step();
    endtask

    task automatic test_stall();
        load_flags(4'b0001);
        step();
        in_valid = 1; cond = 4'hE; flag_w = 0; alu_y = 32'hAAAA; out_ready = 0;
        step();
        alu_y = 32'hBBBB; flag_w = 2'b11; alu_flags = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'hAAAA || flags_q !== 4'b0001) begin
                errors++; $display("FAIL stall_hold cycle %0d: got valid=%b result=%h flags=%b expected 1 aaaa 0001",
                                   i, out_valid, out_result, flags_q);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 0; flag_w = 0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hBBBB || flags_q !== 4'b1111) begin
            errors++; $display("FAIL stall_release: got valid=%b result=%h flags=%b expected 1 bbbb 1111",
                               out_valid, out_result, flags_q);
        end
        step();
    endtask

    task automatic test_flush_and_reset();
        in_valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b0000; flush = 1; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0 || flags_q !== 4'b1111) begin
            errors++; $display("FAIL flush: got valid=%b flags=%b expected 0 1111", out_valid, flags_q);
        end
        flush = 0; flag_w = 0; out_ready = 0;
        step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_fill: got %b expected 1", out_valid); end
        #2;
        reset = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || flags_q !== 4'b0000) begin
            errors++; $display("FAIL async_reset: got valid=%b flags=%b expected 0 0000", out_valid, flags_q);
        end
        idle_inputs();
        step();
        reset = 0;
        step();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_al_flags();
        test_eq_ne();
        test_back_to_back();
        test_cond_table();
        test_stall();
        test_flush_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
